packed_index_checker: RTL and testbench

Multi-lane, pipelined index-to-one-hot decoder with dual re-encoders and a sticky self-check. Each lane takes a binary index, registers its one-hot select vector, and re-encodes that vector by two independent methods. A priority scan gives `id_shift` and a bitwise OR-reduction gives `id_port`. Both results are compared against the original index. This is the generalised successor of the single-lane 32-entry packed-index block: width and lane count are parameters, and it adds range checking, first-error capture and a saturating error counter. It sits beside select-vector datapaths as a debug/assertion unit.

---
 rtl/packed_index_checker.sv | 176 +++++++++++++++++
 tb/tb_packed_index_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packed_index_checker.sv
// packed_index_checker
//   Multi-lane pipelined index -> one-hot decoder with two independent
//   re-encoders (priority scan, OR-reduction) and a sticky self-check.
//   Ports:
//     clk, rst (async, active high), clr (sync clear of sticky state)
//     in_valid[LANES], idx[LANES*IDX_W]          : per-lane index input
//     out_valid[LANES], sel[LANES*WIDTH],
//     id_shift/id_port[LANES*IDX_W]              : per-lane results, 2-cycle latency
//     bad, bad_lane, bad_idx, err_cnt            : sticky first-error capture + counter

// One lane: stage-1 decode register, stage-2 re-encode and result registers.
// Valids are pipelined in the top; this lane sees them as in_valid / v1.
module packed_index_lane #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             v1,
  input  logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] i1,
  output logic             err,
  output logic [WIDTH-1:0] sel,
  output logic [IDX_W-1:0] id_shift,
  output logic [IDX_W-1:0] id_port
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] sel_r;
  logic             rng1;
  logic             in_rng;
  logic [IDX_W-1:0] enc_shift;
  logic [IDX_W-1:0] enc_port;

  // Only reachable when WIDTH is not a power of two.
  assign in_rng = (32'(idx) < 32'(WIDTH));

  // Two deliberately different re-encoders so a corrupted select vector
  // (zero, multi-hot) shows up as a disagreement with the original index.
  always_comb begin
    enc_shift = '0;
    enc_port  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel_r[i]) begin
        enc_shift = IDX_W'(i);
        enc_port  = enc_port | IDX_W'(i);
      end
    end
  end

  assign err = v1 && (rng1 || enc_shift != i1 || enc_port != i1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1       <= '0;
      sel_r    <= '0;
      rng1     <= 1'b0;
      sel      <= '0;
      id_shift <= '0;
      id_port  <= '0;
    end else begin
      i1       <= idx;
      sel_r    <= (in_valid && in_rng) ? (ONE << idx) : '0;
      rng1     <= in_valid && !in_rng;
      // sel_r is already zero for an invalid slot, so these are zero too.
      sel      <= sel_r;
      id_shift <= enc_shift;
      id_port  <= enc_port;
    end
  end

endmodule

module packed_index_checker #(
  parameter int WIDTH = 32,
  parameter int LANES = 2,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int LN_W  = (LANES > 1) ? $clog2(LANES) : 1,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*IDX_W-1:0] idx,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] sel,
  output logic [LANES*IDX_W-1:0] id_shift,
  output logic [LANES*IDX_W-1:0] id_port,
  output logic                   bad,
  output logic [LN_W-1:0]        bad_lane,
  output logic [IDX_W-1:0]       bad_idx,
  output logic [CNT_W-1:0]       err_cnt
);

  localparam int STAGES = 2;
  localparam int PC_W   = $clog2(LANES + 1);
  localparam int SUM_W  = CNT_W + PC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STAGES:1][LANES-1:0] vld_pipe;
  logic [LANES-1:0][IDX_W-1:0] idx_a, i1_a, ids_a, idp_a;
  logic [LANES-1:0][WIDTH-1:0] sel_a;
  logic [LANES-1:0]            err;

  assign idx_a     = idx;
  assign sel       = sel_a;
  assign id_shift  = ids_a;
  assign id_port   = idp_a;
  assign out_valid = vld_pipe[STAGES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    packed_index_lane #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[l]),
      .v1       (vld_pipe[1][l]),
      .idx      (idx_a[l]),
      .i1       (i1_a[l]),
      .err      (err[l]),
      .sel      (sel_a[l]),
      .id_shift (ids_a[l]),
      .id_port  (idp_a[l])
    );
  end

  logic [PC_W-1:0]  pop;
  logic [LN_W-1:0]  first;
  logic [IDX_W-1:0] first_idx;
  logic             any;
  logic             base_bad;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_next;

  // clr wipes the old sticky state but this cycle's errors still land,
  // so everything below works from a "base" that is zero under clr.
  always_comb begin
    pop       = '0;
    first     = '0;
    first_idx = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (err[l]) begin
        first     = LN_W'(l);
        first_idx = i1_a[l];
      end
    end
    for (int l = 0; l < LANES; l++) pop = pop + PC_W'(err[l]);
    any      = |err;
    base_bad = bad & ~clr;
    sum      = SUM_W'(clr ? {CNT_W{1'b0}} : err_cnt) + SUM_W'(pop);
    cnt_next = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      bad      <= 1'b0;
      bad_lane <= '0;
      bad_idx  <= '0;
      err_cnt  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      bad      <= base_bad | any;
      // With no prior error the capture regs are zero anyway, so loading
      // 'first' (zero when nothing erred) is harmless.
      if (!base_bad) begin
        bad_lane <= first;
        bad_idx  <= first_idx;
      end
      err_cnt  <= cnt_next;
    end
  end

endmodule

// File: tb/tb_packed_index_checker.sv
// tb_packed_index_checker
//   Three instances (default; WIDTH=24; WIDTH=24 CNT_W=2) driven by directed
//   and $urandom stimulus, checked every cycle against an abstract model.
module tb_packed_index_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clr;
  logic [1:0] iv [3];
  logic [4:0] ix [3][2];

  logic [1:0]  ov0, ov1, ov2;
  logic [63:0] sel0;
  logic [47:0] sel1, sel2;
  logic [9:0]  ids0, ids1, ids2, idp0, idp1, idp2;
  logic        bad0, bad1, bad2, bl0, bl1, bl2;
  logic [4:0]  bi0, bi1, bi2;
  logic [7:0]  cnt0, cnt1;
  logic [1:0]  cnt2;

  packed_index_checker u_d0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv[0]), .idx({ix[0][1], ix[0][0]}),
    .out_valid(ov0), .sel(sel0), .id_shift(ids0), .id_port(idp0),
    .bad(bad0), .bad_lane(bl0), .bad_idx(bi0), .err_cnt(cnt0));

  packed_index_checker #(.WIDTH(24)) u_d1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv[1]), .idx({ix[1][1], ix[1][0]}),
    .out_valid(ov1), .sel(sel1), .id_shift(ids1), .id_port(idp1),
    .bad(bad1), .bad_lane(bl1), .bad_idx(bi1), .err_cnt(cnt1));

  packed_index_checker #(.WIDTH(24), .CNT_W(2)) u_d2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv[2]), .idx({ix[2][1], ix[2][0]}),
    .out_valid(ov2), .sel(sel2), .id_shift(ids2), .id_port(idp2),
    .bad(bad2), .bad_lane(bl2), .bad_idx(bi2), .err_cnt(cnt2));

  // uniform views of the three instances
  logic [1:0]  a_ov [3];
  logic [31:0] a_sel [3][2];
  logic [4:0]  a_ids [3][2];
  logic [4:0]  a_idp [3][2];
  logic        a_bad [3];
  logic        a_bl [3];
  logic [4:0]  a_bi [3];
  logic [7:0]  a_cnt [3];

  always_comb begin
    a_ov[0] = ov0; a_ov[1] = ov1; a_ov[2] = ov2;
    a_bad[0] = bad0; a_bad[1] = bad1; a_bad[2] = bad2;
    a_bl[0] = bl0; a_bl[1] = bl1; a_bl[2] = bl2;
    a_bi[0] = bi0; a_bi[1] = bi1; a_bi[2] = bi2;
    a_cnt[0] = cnt0; a_cnt[1] = cnt1; a_cnt[2] = {6'h0, cnt2};
    for (int l = 0; l < 2; l++) begin
      a_sel[0][l] = sel0[l*32 +: 32];
      a_sel[1][l] = {8'h0, sel1[l*24 +: 24]};
      a_sel[2][l] = {8'h0, sel2[l*24 +: 24]};
      a_ids[0][l] = ids0[l*5 +: 5]; a_idp[0][l] = idp0[l*5 +: 5];
      a_ids[1][l] = ids1[l*5 +: 5]; a_idp[1][l] = idp1[l*5 +: 5];
      a_ids[2][l] = ids2[l*5 +: 5]; a_idp[2][l] = idp2[l*5 +: 5];
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---- reference model ----
  // A result seen after an edge belongs to the inputs presented one step
  // earlier (captured at the previous edge, emitted at this one).
  localparam int WID [3]  = '{32, 24, 24};
  localparam int CMAX [3] = '{255, 255, 3};
  bit pv [3][2];
  int pi [3][2];
  bit m_bad [3];
  int m_bl [3], m_bi [3], m_cnt [3];

  task automatic mdl_reset();
    for (int k = 0; k < 3; k++) begin
      m_bad[k] = 0; m_bl[k] = 0; m_bi[k] = 0; m_cnt[k] = 0;
      for (int l = 0; l < 2; l++) begin pv[k][l] = 0; pi[k][l] = 0; end
    end
  endtask

  task automatic mdl_edge(input bit c);
    for (int k = 0; k < 3; k++) begin
      int pop, first, fidx;
      pop = 0; first = -1; fidx = 0;
      for (int l = 0; l < 2; l++)
        if (pv[k][l] && pi[k][l] >= WID[k]) begin
          pop++;
          if (first < 0) begin first = l; fidx = pi[k][l]; end
        end
      if (c) begin m_bad[k] = 0; m_bl[k] = 0; m_bi[k] = 0; m_cnt[k] = 0; end
      if (pop > 0 && !m_bad[k]) begin m_bad[k] = 1; m_bl[k] = first; m_bi[k] = fidx; end
      m_cnt[k] = (m_cnt[k] + pop > CMAX[k]) ? CMAX[k] : m_cnt[k] + pop;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      for (int l = 0; l < 2; l++) begin
        bit inr;
        logic [63:0] one;
        one = 64'd1;
        inr = pv[k][l] && pi[k][l] < WID[k];
        chk($sformatf("d%0d.l%0d.out_valid", k, l), 64'(a_ov[k][l]), 64'(pv[k][l]));
        chk($sformatf("d%0d.l%0d.sel", k, l), 64'(a_sel[k][l]), inr ? (one << pi[k][l]) : 64'd0);
        chk($sformatf("d%0d.l%0d.id_shift", k, l), 64'(a_ids[k][l]), inr ? 64'(pi[k][l]) : 64'd0);
        chk($sformatf("d%0d.l%0d.id_port", k, l), 64'(a_idp[k][l]), inr ? 64'(pi[k][l]) : 64'd0);
      end
      chk($sformatf("d%0d.bad", k), 64'(a_bad[k]), 64'(m_bad[k]));
      chk($sformatf("d%0d.bad_lane", k), 64'(a_bl[k]), 64'(m_bl[k]));
      chk($sformatf("d%0d.bad_idx", k), 64'(a_bi[k]), 64'(m_bi[k]));
      chk($sformatf("d%0d.err_cnt", k), 64'(a_cnt[k]), 64'(m_cnt[k]));
    end
  endtask

  // ---- stimulus helpers ----
  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      iv[k] = 2'b00; ix[k][0] = 5'd0; ix[k][1] = 5'd0;
    end
  endtask

  task automatic drive(input int k, input bit v0, input int i0, input bit v1, input int i1);
    iv[k] = {v1, v0}; ix[k][0] = 5'(i0); ix[k][1] = 5'(i1);
  endtask

  task automatic step(input bit c);
    clr = c;
    @(posedge clk); #1;
    mdl_edge(c);
    check_all();
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < 2; l++) begin pv[k][l] = iv[k][l]; pi[k][l] = int'(ix[k][l]); end
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    idle_all();
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();                         // reset state
    rst = 1'b0;

    // directed: lane0=5, lane1=31 on the default instance
    drive(0, 1, 5, 1, 31);
    step(0);
    idle_all();
    step(0);
    chk("dir.out_valid", 64'(a_ov[0]), 64'h3);
    chk("dir.sel0", 64'(a_sel[0][0]), 64'h0000_0020);
    chk("dir.sel1", 64'(a_sel[0][1]), 64'h8000_0000);
    chk("dir.ids1", 64'(a_ids[0][1]), 64'd31);
    chk("dir.idp0", 64'(a_idp[0][0]), 64'd5);
    chk("dir.bad", 64'(a_bad[0]), 64'd0);

    // sweep 0..31 back-to-back on every instance
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < 3; k++) drive(k, 1, i, 1, 31 - i);
      step(0);
    end
    idle_all();
    step(0);
    chk("sweep.err_cnt", 64'(a_cnt[0]), 64'd0);

    // WIDTH=24: first capture on lane1, later lane0 error only counts
    step(1);
    drive(1, 0, 0, 1, 30); step(0);
    idle_all();            step(0);
    chk("w24.bad", 64'(a_bad[1]), 64'd1);
    chk("w24.bad_lane", 64'(a_bl[1]), 64'd1);
    chk("w24.bad_idx", 64'(a_bi[1]), 64'd30);
    chk("w24.err_cnt1", 64'(a_cnt[1]), 64'd1);
    drive(1, 1, 28, 0, 0); step(0);
    idle_all();            step(0);
    chk("w24.hold_lane", 64'(a_bl[1]), 64'd1);
    chk("w24.hold_idx", 64'(a_bi[1]), 64'd30);
    chk("w24.err_cnt2", 64'(a_cnt[1]), 64'd2);
    step(1);
    chk("w24.clr_bad", 64'(a_bad[1]), 64'd0);
    chk("w24.clr_cnt", 64'(a_cnt[1]), 64'd0);

    // simultaneous errors: lowest lane wins
    drive(1, 1, 25, 1, 25); step(0);
    idle_all();             step(0);
    chk("w24.both_lane", 64'(a_bl[1]), 64'd0);
    chk("w24.both_cnt", 64'(a_cnt[1]), 64'd2);
    step(1);
    chk("w24.clr2_idx", 64'(a_bi[1]), 64'd0);

    // clr coinciding with an error: fresh capture
    drive(1, 0, 0, 1, 27); step(0);
    idle_all();            step(1);
    chk("w24.clr_err_bad", 64'(a_bad[1]), 64'd1);
    chk("w24.clr_err_cnt", 64'(a_cnt[1]), 64'd1);

    // CNT_W=2 saturation
    step(1);
    for (int j = 0; j < 5; j++) begin
      drive(2, 1, 24 + j, 0, 0); step(0);
    end
    idle_all(); step(0);
    chk("sat.err_cnt", 64'(a_cnt[2]), 64'd3);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 3; k++)
        drive(k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
      step($urandom_range(0, 15) == 0);
    end

    // reset with results in flight
    for (int k = 0; k < 3; k++) drive(k, 1, 3, 1, 30);
    step(0);
    step(0);
    rst = 1'b1;
    #1;
    mdl_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    idle_all();
    rst = 1'b0;
    step(0);
    step(0);
    chk("rst.no_valid", 64'(a_ov[0]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
